// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory initiator: access type
// codes, exception codes, FSM states and the access-type decoder.
package mem_access_unit_pkg;

    localparam logic [3:0] TYPE_WORD  = 4'b0000;
    localparam logic [3:0] TYPE_HALF  = 4'b0010;
    localparam logic [3:0] TYPE_HALFU = 4'b0011;
    localparam logic [3:0] TYPE_BYTE  = 4'b0100;
    localparam logic [3:0] TYPE_BYTEU = 4'b0101;
    localparam logic [3:0] TYPE_WL    = 4'b0110;
    localparam logic [3:0] TYPE_WR    = 4'b0111;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mau_state_e;

    typedef enum logic [2:0] {
        ACC_WORD,
        ACC_HALF,
        ACC_HALFU,
        ACC_BYTE,
        ACC_BYTEU,
        ACC_WL,
        ACC_WR
    } acc_kind_e;

    // Unlisted codes fall back to a plain word access.
    function automatic acc_kind_e decode_type(input logic [3:0] op_type);
        acc_kind_e kind;
        case (op_type)
            TYPE_WORD:  kind = ACC_WORD;
            TYPE_HALF:  kind = ACC_HALF;
            TYPE_HALFU: kind = ACC_HALFU;
            TYPE_BYTE:  kind = ACC_BYTE;
            TYPE_BYTEU: kind = ACC_BYTEU;
            TYPE_WL:    kind = ACC_WL;
            TYPE_WR:    kind = ACC_WR;
            default:    kind = ACC_WORD;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: misalignment detection, store byte enables and
// lane-shifted store data, and load extraction / extension / rt merge.
module mau_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic        we,
    input  logic [3:0]  op_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    acc_kind_e   kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign kind = decode_type(op_type);

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misaligned = 1'b0;
        ld_data    = rdata;
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (kind)
            ACC_HALF, ACC_HALFU: begin
                misaligned = addr_lo[0];
                if (we) begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                ld_data = (kind == ACC_HALF) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
            end
            ACC_BYTE, ACC_BYTEU: begin
                if (we) begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                ld_data = (kind == ACC_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h000000, byte_sel};
            end
            // Word-left fills the high-order bytes of rt, word-right the low ones.
            ACC_WL: begin
                if (we) begin
                    be         = 4'b1111 >> (~addr_lo);
                    wdata_lane = wdata >> {~addr_lo, 3'b000};
                end
                case (addr_lo)
                    2'd0:    ld_data = {rdata[7:0],  rt_old[23:0]};
                    2'd1:    ld_data = {rdata[15:0], rt_old[15:0]};
                    2'd2:    ld_data = {rdata[23:0], rt_old[7:0]};
                    default: ld_data = rdata;
                endcase
            end
            ACC_WR: begin
                if (we) begin
                    be         = 4'b1111 << addr_lo;
                    wdata_lane = wdata << {addr_lo, 3'b000};
                end
                case (addr_lo)
                    2'd0:    ld_data = rdata;
                    2'd1:    ld_data = {rt_old[31:24], rdata[31:8]};
                    2'd2:    ld_data = {rt_old[31:16], rdata[31:16]};
                    default: ld_data = {rt_old[31:8],  rdata[31:24]};
                endcase
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-organised data memory with req/ack handshake.
// Holds the pipeline while an access is outstanding and reports AdEL/AdES/DBE.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [3:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_rt_old,
    input  logic [31:0] op_pc,
    output logic        stall,
    output logic        done,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_occur,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    mau_state_e  state_reg, state_next;
    logic [31:0] timer_reg;
    logic        op_we_reg;
    logic [3:0]  op_type_reg;
    logic [1:0]  addr_lo_reg;
    logic [31:0] rt_old_reg;

    logic        done_reg, ld_valid_reg, exc_occur_reg, mem_req_reg, mem_we_reg;
    logic [31:0] ld_data_reg, exc_pc_reg, mem_addr_reg, mem_wdata_reg;
    logic [4:0]  exc_code_reg;
    logic [3:0]  mem_be_reg;

    logic        sel_live;
    logic        lane_we;
    logic [3:0]  lane_type;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misaligned;
    logic [31:0] lane_ld_data;
    logic        timeout_hit;

    // In IDLE the lane logic sees the incoming op; afterwards the captured copy.
    assign sel_live     = (state_reg == ST_IDLE);
    assign lane_we      = sel_live ? op_we          : op_we_reg;
    assign lane_type    = sel_live ? op_type        : op_type_reg;
    assign lane_addr_lo = sel_live ? op_addr[1:0]   : addr_lo_reg;

    mau_lane_align u_lane_align (
        .we         (lane_we),
        .op_type    (lane_type),
        .addr_lo    (lane_addr_lo),
        .wdata      (op_wdata),
        .rt_old     (rt_old_reg),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .misaligned (lane_misaligned),
        .ld_data    (lane_ld_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == 32'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (op_valid) state_next = lane_misaligned ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mem_ack || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            op_we_reg     <= 1'b0;
            op_type_reg   <= '0;
            addr_lo_reg   <= '0;
            rt_old_reg    <= '0;
            done_reg      <= 1'b0;
            ld_valid_reg  <= 1'b0;
            ld_data_reg   <= '0;
            exc_occur_reg <= 1'b0;
            exc_code_reg  <= EXC_NONE;
            exc_pc_reg    <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= 1'b0;
            ld_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_we_reg   <= op_we;
                        op_type_reg <= op_type;
                        addr_lo_reg <= op_addr[1:0];
                        rt_old_reg  <= op_rt_old;
                        exc_pc_reg  <= op_pc;
                        timer_reg   <= '0;
                        if (lane_misaligned) begin
                            done_reg      <= 1'b1;
                            exc_occur_reg <= 1'b1;
                            exc_code_reg  <= op_we ? EXC_ADES : EXC_ADEL;
                        end else begin
                            exc_occur_reg <= 1'b0;
                            exc_code_reg  <= EXC_NONE;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= op_we;
                            mem_addr_reg  <= {op_addr[31:2], 2'b00};
                            mem_be_reg    <= lane_be;
                            mem_wdata_reg <= lane_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    // An ack arriving with the final timer tick still completes normally.
                    if (mem_ack) begin
                        mem_req_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                        ld_valid_reg <= ~op_we_reg;
                        if (!op_we_reg) ld_data_reg <= lane_ld_data;
                    end else if (timeout_hit) begin
                        mem_req_reg   <= 1'b0;
                        done_reg      <= 1'b1;
                        exc_occur_reg <= 1'b1;
                        exc_code_reg  <= EXC_DBE;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall     = op_valid & (state_reg != ST_DONE);
    assign done      = done_reg;
    assign ld_valid  = ld_valid_reg;
    assign ld_data   = ld_data_reg;
    assign exc_occur = exc_occur_reg;
    assign exc_code  = exc_code_reg;
    assign exc_pc    = exc_pc_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory interface. Sits in the MEM stage between the pipeline and a word-organised data memory with a req/ack handshake. It checks alignment and raises AdEL/AdES, builds byte enables and lane-shifted store data, issues one memory transaction per access, and returns aligned, extended or merged load data. It stalls the pipeline until each access completes; a bus timeout raises DBE.

## Interface
Parameters:
- TIMEOUT, 255, BUSY cycles without mem_ack before DBE; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  memory instruction present; held stable while stall=1
- op_we  in  1  1 = store, 0 = load
- op_type  in  4  access type (see Operation)
- op_addr  in  32  byte address
- op_wdata  in  32  store data (rt)
- op_rt_old  in  32  current rt value, merged for word-left/word-right loads
- op_pc  in  32  PC of the instruction
- stall  out  1  freeze pipeline
- done  out  1  one-cycle completion pulse
- ld_valid  out  1  ld_data valid (load completed without exception)
- ld_data  out  32  final register-file write value
- exc_occur  out  1  exception for this access (qualified by done)
- exc_code  out  5  ADEL=4, ADES=5, DBE=7; 0 otherwise
- exc_pc  out  32  captured op_pc
- mem_req  out  1  request
- mem_we  out  1  write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  request completes this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

## Operation
Type codes:
- 0000 word
- 0010 half signed
- 0011 half unsigned
- 0100 byte signed
- 0101 byte unsigned
- 0110 word-left
- 0111 word-right
- Any other code is treated as word.
- Stores ignore the signed/unsigned distinction.

Alignment (a = addr[1:0]):
- word needs a=00; half needs a[0]=0; byte, word-left and word-right are never misaligned.
- A misaligned access raises ADES for a store and ADEL for a load, and issues no memory request.

Store lanes:
- byte: be = 1<<a; data = {4{wd[7:0]}}
- half: be = a[1] ? 1100 : 0011; data = {2{wd[15:0]}}
- word: be = 1111; data = wd
- word-left, a=0/1/2/3: be = 0001/0011/0111/1111; data = wd>>24 / >>16 / >>8 / wd
- word-right, a=0/1/2/3: be = 1111/1110/1100/1000; data = wd / <<8 / <<16 / <<24

Load data (w = mem_rdata, r = op_rt_old):
- Loads always use be=1111.
- byte and half: the selected lane, sign- or zero-extended per type.
- word-left, a=0: {w[7:0], r[23:0]}; a=1: {w[15:0], r[15:0]}; a=2: {w[23:0], r[7:0]}; a=3: w.
- word-right, a=0: w; a=1: {r[31:24], w[31:8]}; a=2: {r[31:16], w[31:16]}; a=3: {r[31:8], w[31:24]}.

FSM IDLE / BUSY / DONE:
- IDLE
  - op_valid with a misaligned access: capture the op, go to DONE with an exception.
  - op_valid with an aligned access: capture the op and computed lanes, go to BUSY.
- BUSY
  - mem_req=1 with all mem_* outputs stable.
  - mem_ack: register load data, go to DONE.
  - Else the timer reaches TIMEOUT: drop mem_req, go to DONE with DBE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: done=1; ld_valid=1 if the op was a load with no exception; then return to IDLE.
- stall = op_valid & (state != DONE).
- The pipeline advances on the edge that ends DONE.
- mem_ack seen outside BUSY is ignored.

## Timing
- All outputs are registered except stall.
- Reset values: every output 0; state IDLE; timer 0.
- Latency, aligned access: op cycle 0 (IDLE) → BUSY from cycle 1 → DONE in the cycle after the ack. With an immediate ack, done is in cycle 2, and stall is high in cycles 0–1.
- Latency, misaligned access: done in cycle 1.
- Reset mid-BUSY: mem_req is 0 after the reset edge and no done is produced.
- Back-to-back ops: a new op is accepted the cycle after DONE.

## Structure
- Type codes and EXC_ADEL/EXC_ADES/EXC_DBE go in the shared macro header.
- One combinational sub-module, mau_lane_align, computes be, wdata, misalignment and the load merge/extension. The FSM, registers and timer stay in the top module.

## Test plan
- SB to addr 0x13 with wd=0x000000AB, ack after 2 BUSY cycles → mem_addr 0x10, be 1000, wdata 0xABABABAB; done in the cycle after the ack; exc 0.
- LH signed at 0x22 with rdata 0x8001_7FFF → ld_data 0xFFFF8001; LHU at the same address → 0x00008001.
- LW at 0x05 → no mem_req; done in cycle 1; exc_code 4; exc_pc = op_pc. SH at 0x07 → exc_code 5.
- LWL a=1 with rdata 0x11223344 and rt 0xAABBCCDD → 0x3344CCDD. LWR a=2 → 0xAABB1122. SWR a=1 with wd 0x11223344 → be 1110, wdata 0x22334400.
- TIMEOUT=4 with mem_ack held low → mem_req high for exactly 4 cycles, then done with exc_code 7 and ld_valid 0. An ack in the 4th cycle completes normally instead.
- Reset asserted during BUSY → next cycle all outputs 0 and no done; a following op completes normally.
